// File: rtl/prog_engine_pkg.sv
// ---------------------------------------------------------------------------
// prog_engine_pkg
// Shared types for the block-operation engine: operation modes, FSM states
// and the default watchdog limit.
// Optional feature macro: PROG_ENGINE_SUM_EN (see prog_engine.sv).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package prog_engine_pkg;

   // Default number of op-state cycles before a forced abort.
   localparam int unsigned TIMEOUT_DEFAULT = 1023;

   typedef enum logic [1:0] {
      MODE_COPY = 2'd0,
      MODE_FILL = 2'd1,
      MODE_SUM  = 2'd2,
      MODE_ILL  = 2'd3
   } mode_e;

   // ACC and SUMWR are only reachable when the SUM feature is compiled in.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_RD    = 3'd2,
      ST_WR    = 3'd3,
      ST_ACC   = 3'd4,
      ST_SUMWR = 3'd5,
      ST_DONE  = 3'd6
   } state_e;

endpackage

`default_nettype wire

// File: rtl/prog_engine_watchdog.sv
// ---------------------------------------------------------------------------
// cycle_watchdog
// Saturating CW-bit op-cycle counter with synchronous clear and count enable.
// hit_o is high while the count equals TIMEOUT.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   clr_i         clear count to zero (has priority over en_i)
//   en_i          count one cycle
//   count_o       current count
//   hit_o         count == TIMEOUT
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cycle_watchdog #(
   parameter int          CW      = 16,
   parameter int unsigned TIMEOUT = prog_engine_pkg::TIMEOUT_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [CW-1:0] count_o,
   output logic          hit_o
);

   localparam logic [CW-1:0] C_LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != '1)) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign hit_o   = (count_q == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/prog_engine.sv
// ---------------------------------------------------------------------------
// prog_engine
// Block operation engine (COPY / FILL / SUM) over data memory, started by a
// req/ack handshake: req high arms the engine, req falling starts the run.
// Reports completion (ack), status (err) and op-cycle count (cycles).
// Optional feature macro: PROG_ENGINE_SUM_EN - compiles in SUM mode, the
// ACC/SUMWR states and the accumulator. Without it mode 2 is illegal.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   req               high = hold/restart, low in ARMED = run
//   mode              0 COPY, 1 FILL, 2 SUM, 3 illegal
//   src_base/dst_base source / destination start address
//   len               element count 0..2^AW
//   fill_val          FILL data
//   ack/err/busy      done / error status / op state active
//   cycles            op-state cycle count
//   MemAdr/DatIn/DatOut/ReadEn/WriteEn  memory port (read data one cycle late)
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module prog_engine #(
   parameter int          DW      = 8,
   parameter int          AW      = 8,
   parameter int          CW      = 16,
   parameter int unsigned TIMEOUT = prog_engine_pkg::TIMEOUT_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic [1:0]    mode,
   input  logic [AW-1:0] src_base,
   input  logic [AW-1:0] dst_base,
   input  logic [AW:0]   len,
   input  logic [DW-1:0] fill_val,
   output logic          ack,
   output logic          err,
   output logic          busy,
   output logic [CW-1:0] cycles,
   output logic [AW-1:0] MemAdr,
   output logic [DW-1:0] DatIn,
   input  logic [DW-1:0] DatOut,
   output logic          ReadEn,
   output logic          WriteEn
);

   import prog_engine_pkg::*;

   state_e        state_q, state_d;
   mode_e         mode_q,  mode_d;
   logic [AW-1:0] src_q,   src_d;
   logic [AW-1:0] dst_q,   dst_d;
   logic [AW:0]   len_q,   len_d;
   logic [DW-1:0] fill_q,  fill_d;
   logic [AW:0]   idx_q,   idx_d;
   logic          err_q,   err_d;
`ifdef PROG_ENGINE_SUM_EN
   logic [DW-1:0] acc_q,   acc_d;
`endif

   logic          wd_hit;
   logic          mode_ok;
   mode_e         mode_in;
   logic [AW:0]   idx_inc;
   logic          last_elem;
   logic [AW-1:0] src_addr;
   logic [AW-1:0] dst_addr;

   assign mode_in = mode_e'(mode);

`ifdef PROG_ENGINE_SUM_EN
   assign mode_ok = (mode_in != MODE_ILL);
`else
   assign mode_ok = (mode_in == MODE_COPY) || (mode_in == MODE_FILL);
`endif

   assign idx_inc   = idx_q + (AW+1)'(1);
   assign last_elem = (idx_inc == len_q);
   // Address arithmetic wraps modulo 2^AW by truncation.
   assign src_addr  = src_q + idx_q[AW-1:0];
   assign dst_addr  = dst_q + idx_q[AW-1:0];

   assign busy = (state_q == ST_RD) || (state_q == ST_WR) ||
                 (state_q == ST_ACC) || (state_q == ST_SUMWR);
   assign ack  = (state_q == ST_DONE);
   assign err  = err_q;

   // The limit cycle itself is not counted: it becomes the abort cycle.
   cycle_watchdog #(
      .CW      (CW),
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (req),
      .en_i    (busy && !wd_hit && !req),
      .count_o (cycles),
      .hit_o   (wd_hit)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      fill_d  = fill_q;
      idx_d   = idx_q;
      err_d   = err_q;
`ifdef PROG_ENGINE_SUM_EN
      acc_d   = acc_q;
`endif
      MemAdr  = '0;
      DatIn   = '0;
      ReadEn  = 1'b0;
      WriteEn = 1'b0;

      if (req) begin
         // Restart wins over everything, including a completion edge.
         state_d = ST_ARMED;
         idx_d   = '0;
         err_d   = 1'b0;
`ifdef PROG_ENGINE_SUM_EN
         acc_d   = '0;
`endif
      end else if (busy && wd_hit) begin
         // Timeout abort: no memory access in this cycle.
         state_d = ST_DONE;
         err_d   = 1'b1;
      end else begin
         case (state_q)
            ST_ARMED: begin
               mode_d = mode_in;
               src_d  = src_base;
               dst_d  = dst_base;
               len_d  = len;
               fill_d = fill_val;
               if (!mode_ok) begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
               end else if (len == '0) begin
                  state_d = ST_DONE;
               end else if (mode_in == MODE_FILL) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
            end

            ST_RD: begin
               MemAdr  = src_addr;
               ReadEn  = 1'b1;
               state_d = ST_WR;
`ifdef PROG_ENGINE_SUM_EN
               if (mode_q == MODE_SUM) begin
                  state_d = ST_ACC;
               end
`endif
            end

            ST_WR: begin
               MemAdr  = dst_addr;
               WriteEn = 1'b1;
               // COPY forwards the word read in the preceding RD cycle.
               DatIn   = (mode_q == MODE_FILL) ? fill_q : DatOut;
               idx_d   = idx_inc;
               if (last_elem) begin
                  state_d = ST_DONE;
               end else if (mode_q == MODE_FILL) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
            end

`ifdef PROG_ENGINE_SUM_EN
            ST_ACC: begin
               acc_d   = acc_q + DatOut;
               idx_d   = idx_inc;
               state_d = last_elem ? ST_SUMWR : ST_RD;
            end

            ST_SUMWR: begin
               MemAdr  = dst_q;
               WriteEn = 1'b1;
               DatIn   = acc_q;
               state_d = ST_DONE;
            end
`endif

            ST_IDLE: state_d = ST_IDLE;
            ST_DONE: state_d = ST_DONE;

            default: begin
               // Unreachable encodings end the run as an error.
               state_d = ST_DONE;
               err_d   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_COPY;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         fill_q  <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         fill_q  <= fill_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

`ifdef PROG_ENGINE_SUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`endif

endmodule

`default_nettype wire

// File: doc/prog_engine.md
# prog_engine

Parametrised successor to the dummy test-bench processor. It performs a block operation over data memory on a req/ack handshake with the test bench, then reports completion, status and cycle count. The operation is one of copy, fill or sum. It sits between the test bench and `dm` and drives the memory address, data and enable lines directly.

## Interface
- `DW`, 8: data width; matches `dm` word width.
- `AW`, 8: address width; memory depth is 2^AW.
- `CW`, 16: cycle-counter width.
- `TIMEOUT`, 1023: maximum number of op-state cycles before a forced abort; must be less than 2^CW.
- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  test-bench "start program"; high = hold/restart, falling edge = run.
- `mode`  in  2  0 COPY, 1 FILL, 2 SUM, 3 illegal.
- `src_base`  in  AW  source start address.
- `dst_base`  in  AW  destination start address.
- `len`  in  AW+1  element count, 0..2^AW.
- `fill_val`  in  DW  FILL data.
- `ack`  out  1  done; held high until the next `req`.
- `err`  out  1  valid while `ack` is high; 1 = timeout or illegal mode.
- `busy`  out  1  high in op states.
- `cycles`  out  CW  op-state cycle count; saturates at 2^CW-1.
- `MemAdr`  out  AW  memory address.
- `DatIn`  out  DW  memory write data.
- `DatOut`  in  DW  memory read data; valid one cycle after a `ReadEn` cycle.
- `ReadEn`, `WriteEn`  out  1  memory enables; never both high in the same cycle.

## Operation
- States: IDLE, ARMED, RD, WR, ACC, SUMWR, DONE.
- Any cycle with `req`=1, in any state: next state is ARMED. This clears `ack`, `err`, `cycles` and the index. `WriteEn` and `ReadEn` are gated low in that cycle.
- ARMED with `req`=0:
  - Latch `mode`, `src_base`, `dst_base`, `len`, `fill_val`; later input changes are ignored.
  - Go to the first op state.
  - If `len`=0 go to DONE with err=0.
  - If mode 3 go to DONE with err=1.
- COPY, per element i:
  - RD: `MemAdr`=src+i, `ReadEn`=1.
  - WR: `MemAdr`=dst+i, `DatIn`=`DatOut`, `WriteEn`=1.
- FILL, per element i: WR only, with `MemAdr`=dst+i and `DatIn`=`fill_val`.
- SUM:
  - Per element i: RD on src+i, then ACC computes acc = acc + `DatOut` mod 2^DW.
  - After the last element: SUMWR writes acc to `dst_base`.
- Address arithmetic is mod 2^AW; src+i and dst+i wrap silently past 2^AW-1.
- Overlapping COPY regions are processed in ascending index order with no hazard protection.
- DONE: `ack`=1 and `busy`=0; the engine stays in DONE until `req`=1.
- IDLE is entered only from reset; `ack`=0 there.

## Timing
- Reset values: `ack`=0, `err`=0, `busy`=0, `cycles`=0, `MemAdr`=0, `DatIn`=0, `ReadEn`=0, `WriteEn`=0. Reset mid-operation aborts immediately and asynchronously, with no further memory access.
- `cycles` increments on every clock edge that ends an op-state cycle (RD, WR, ACC, SUMWR).
- `ack` rises on the edge that ends the final op cycle. Counted from the first ARMED cycle with `req`=0:

| Mode | Op cycles | Edges until `ack` rises |
|---|---|---|
| COPY | 2N | 2N+1 |
| FILL | N | N+1 |
| SUM | 2N+1 | 2N+2 |

- `len`=0 or mode 3: `ack` rises 1 edge after the first ARMED cycle with `req`=0, with `cycles`=0.
- Timeout: when `cycles` reaches `TIMEOUT`, the next state is DONE with err=1. No write is issued in the cycle the limit is hit.
- `req` asserted on the same edge as completion: `req` wins; the engine goes to ARMED and `ack` stays 0.

## Configuration
- `PROG_ENGINE_SUM_EN` defined: SUM mode, the ACC and SUMWR states, and the accumulator are compiled in.
- `PROG_ENGINE_SUM_EN` undefined: mode 2 behaves exactly like mode 3, i.e. an immediate DONE with err=1 and no memory access.

## Structure
- Package `prog_engine_pkg` holds:
  - the mode enum (`MODE_COPY`, `MODE_FILL`, `MODE_SUM`, `MODE_ILL`);
  - the state enum;
  - default `TIMEOUT`.
- One sub-module, `cycle_watchdog`: a saturating CW-bit counter with clear and enable inputs and a `hit` output at `TIMEOUT`.
- The FSM, index register and accumulator stay in `prog_engine`.

## Test plan
- COPY, src=0x10, dst=0x80, len=4, memory [0x10..0x13]=1,2,3,4 → [0x80..0x83]=1,2,3,4; ack after 9 edges; cycles=8; err=0.
- FILL, dst=0xFE, len=3, fill_val=0xA5 → 0xFE, 0xFF, 0x00 written with 0xA5 (address wrap); cycles=3.
- SUM (macro on), src=0x00, len=3, data 0x80, 0x90, 0x10 → 0x20 at dst_base; cycles=7. With the macro off, the same stimulus gives ack with err=1, cycles=0 and no writes.
- Illegal mode and `len`=0 cases:
  - mode=3 → ack and err=1 one edge after the `req` fall, with no memory access;
  - `len`=0 in COPY → ack with err=0.
- TIMEOUT=5, COPY len=10 → ack with err=1 and cycles=5; exactly 2 destination writes.
- Restart and reset mid-run:
  - `req` re-asserted mid-COPY → ack=0, no write in that cycle, cycles=0; the next run completes normally.
  - async `reset` mid-FILL → all outputs at reset values before the next edge.
